// File: rtl/dec_38_seq.sv
// rtl/dec_38_seq.sv - sequenced 3-to-8 one-hot decoder with a one-entry pending buffer
// Optional macro DEC38_PARITY_EN adds in_par (odd parity over {in_idx,in_par}) and par_err.
module dec_38_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [2:0] in_idx,
`ifdef DEC38_PARITY_EN
  input  logic       in_par,
  output logic       par_err,
`endif
  output logic       in_ready,
  output logic [7:0] d_out,
  output logic       out_valid,
  output logic       busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_GAP} state_t;

  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LD  = 8'(GAP_CYCLES - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_dout;
  logic       r_out_valid;
  logic       r_pend_vld;
  logic [2:0] r_pend_idx;

  state_t     w_state_nx;
  logic [7:0] w_cnt_nx;
  logic [7:0] w_dout_nx;
  logic       w_out_valid_nx;
  logic       w_pend_vld_nx;
  logic [2:0] w_pend_idx_nx;
  logic       w_xfer;
  logic       w_use;
  logic       w_next_vld;
  logic [2:0] w_next_idx;
  logic       w_load;

  assign in_ready  = (r_state == ST_IDLE) || !r_pend_vld;
  assign busy      = (r_state != ST_IDLE) || r_pend_vld;
  assign d_out     = r_dout;
  assign out_valid = r_out_valid;
  assign w_xfer    = in_valid && in_ready;

`ifdef DEC38_PARITY_EN
  logic w_par_ok;
  logic r_par_err;
  assign w_par_ok = ^{in_idx, in_par};
  assign w_use    = w_xfer && w_par_ok;
  assign par_err  = r_par_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_par_err <= 1'b0;
    else        r_par_err <= w_xfer && !w_par_ok;
  end
`else
  assign w_use = w_xfer;
`endif

  // Pending entry has priority; otherwise a same-cycle transfer bypasses the buffer.
  assign w_next_vld = r_pend_vld || w_use;
  assign w_next_idx = r_pend_vld ? r_pend_idx : in_idx;

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_dout_nx      = r_dout;
    w_out_valid_nx = r_out_valid;
    w_load         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_next_vld) w_load = 1'b1;
      end
      ST_DRIVE: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nx = r_cnt - 8'd1;
        end else if (GAP_CYCLES > 0) begin
          w_state_nx     = ST_GAP;
          w_dout_nx      = 8'h00;
          w_out_valid_nx = 1'b0;
          w_cnt_nx       = GAP_LD;
        end else if (w_next_vld) begin
          w_load = 1'b1;
        end else begin
          w_state_nx     = ST_IDLE;
          w_dout_nx      = 8'h00;
          w_out_valid_nx = 1'b0;
        end
      end
      ST_GAP: begin
        if (r_cnt != 8'd0) w_cnt_nx = r_cnt - 8'd1;
        else if (w_next_vld) w_load = 1'b1;
        else w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx     = ST_IDLE;
        w_dout_nx      = 8'h00;
        w_out_valid_nx = 1'b0;
        w_cnt_nx       = 8'd0;
      end
    endcase

    if (w_load) begin
      w_state_nx     = ST_DRIVE;
      w_dout_nx      = 8'b1 << w_next_idx;
      w_out_valid_nx = 1'b1;
      w_cnt_nx       = HOLD_LD;
    end

    w_pend_vld_nx = r_pend_vld;
    w_pend_idx_nx = r_pend_idx;
    if (w_load && r_pend_vld) w_pend_vld_nx = 1'b0;
    if (w_use && !(w_load && !r_pend_vld)) begin
      w_pend_vld_nx = 1'b1;
      w_pend_idx_nx = in_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 8'd0;
      r_dout      <= 8'h00;
      r_out_valid <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_idx  <= 3'd0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_dout      <= w_dout_nx;
      r_out_valid <= w_out_valid_nx;
      r_pend_vld  <= w_pend_vld_nx;
      r_pend_idx  <= w_pend_idx_nx;
    end
  end

endmodule

// File: doc/dec_38_seq.md
Name: dec_38_seq

Overview:
- Sequenced 3-to-8 one-hot decoder. It is the consumer-side counterpart of the 8-to-3 priority encoder.
- Accepts 3-bit indices over a valid/ready handshake. Each index drives one registered one-hot line for a fixed number of cycles, then a fixed idle gap follows.
- A one-entry pending buffer lets the upstream encoder issue the next index while the current one is still being driven.
- Used to turn encoded channel/request numbers back into per-line select/strobe pulses.

Parameters:
HOLD_CYCLES, 4, cycles each one-hot pattern is driven; legal range 1..255
GAP_CYCLES, 1, forced all-zero cycles between consecutive patterns; legal range 0..255

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_idx is valid this cycle
in_idx  input  3  index to decode (0..7)
in_ready  output  1  block can accept in_idx this cycle
d_out  output  8  registered one-hot output; bit in_idx is set during DRIVE
out_valid  output  1  high exactly while d_out is non-zero (DRIVE state)
busy  output  1  high when state is not IDLE or the pending buffer is full

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset state: state=IDLE, d_out=8'h00, out_valid=0, pending buffer empty, counter=0. in_ready=1 and busy=0 combinationally once reset releases.
- Reset mid-operation: all state clears immediately. The pending index is discarded, and d_out drops to 0 asynchronously.
- Handshake: a transfer occurs on a rising edge where in_valid and in_ready are both 1. in_idx is sampled only on a transfer. in_idx is ignored when in_valid is 0.
- in_ready is 1 in IDLE, and 1 in DRIVE or GAP when the pending buffer is empty. Otherwise it is 0. in_ready does not depend on in_valid.
- States: IDLE, DRIVE, GAP. The counter is wide enough for 255.
- IDLE, transfer (or pending full, which cannot occur in IDLE): go to DRIVE on the next edge.
  - d_out <= 1<<idx, out_valid<=1, counter<=HOLD_CYCLES-1.
  - Latency from transfer edge to d_out valid is 1 clock.
- DRIVE: counter decrements each cycle. When counter==0:
  - if GAP_CYCLES>0: go to GAP, d_out<=0, out_valid<=0, counter<=GAP_CYCLES-1;
  - if GAP_CYCLES==0 and a next index exists: stay in DRIVE and load it;
  - if GAP_CYCLES==0 and no next index exists: go to IDLE with d_out<=0.
- Next index: the pending buffer if it is full; otherwise a transfer in the same cycle (bypass). When both exist, the pending entry is consumed and the same-cycle transfer fills the buffer.
- GAP: counter decrements. When counter==0: if a next index exists, go to DRIVE and load it; else go to IDLE.
- During DRIVE or GAP, a transfer that is not consumed in the same cycle writes the pending buffer.
- Each pattern lasts exactly HOLD_CYCLES cycles. Each gap lasts exactly GAP_CYCLES cycles.
- Back-to-back patterns with GAP_CYCLES==0 show no zero cycle between them, even for the same index.
- d_out is always either 0 or exactly one bit set.

Optional Feature:
- Macro: DEC38_PARITY_EN.
- When defined:
  - Adds input in_par (1 bit, odd parity over {in_idx,in_par}) and output par_err (1 bit, registered, reset 0).
  - A transfer with bad parity is accepted (handshake completes) but discarded: no state change, no pending write.
  - par_err pulses high for exactly 1 cycle, on the edge after the transfer.
- When undefined: the ports are absent, and every transfer is used.

Test Plan:
- Reset, then a single transfer idx=5 with HOLD=4, GAP=1 -> one clock later d_out=8'h20 and out_valid=1 for 4 cycles; then 1 cycle of 0; then IDLE with in_ready=1.
- Assert rst_n low while d_out=8'h80 with the pending buffer full -> d_out=0 immediately; after release, no pattern from the discarded entry appears.
- in_valid held high, idx sequence 0,1,2 with HOLD=2, GAP=1 -> d_out 01,01,00,02,02,00,04,04,00; in_ready=0 whenever pending is full; no index lost.
- GAP_CYCLES=0, HOLD=1, continuous transfers 3,3,6 -> d_out 08,08,40 on consecutive cycles; out_valid stays high throughout.
- in_valid=1 with in_idx toggling while in_ready=0 -> those values are ignored; only handshaked indices appear on d_out.
- DEC38_PARITY_EN defined, transfer idx=2 with bad parity -> par_err=1 for 1 cycle, d_out stays 0; the next good idx=2 gives d_out=8'h04.
